// File: rtl/mant_mult_seq.sv
// Radix-2 shift-and-add multiplier for single-precision significands (hidden 1 restored).
// Produces the normalized truncated fraction, the exponent-increment flag and a sticky bit.
module mant_mult_seq #(
    parameter int MW = 23
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          start,
    input  logic [MW-1:0] man1,
    input  logic [MW-1:0] man2,
    output logic [MW-1:0] mant,
    output logic          inc_exp,
    output logic          sticky,
    output logic          busy,
    output logic          done
);

    localparam int SW = MW + 1;
    localparam int PW = 2 * SW;
    localparam int CW = $clog2(SW);
    localparam logic [CW-1:0] LAST = CW'(SW - 1);

    typedef enum logic [1:0] {IDLE, RUN, NORM, DONE} state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] a, b;
    logic [PW-1:0] p;
    logic [CW-1:0] cnt;
    logic [SW:0]   sum;

    // Partial-product add into the upper half; the carry becomes the new MSB after the shift.
    assign sum = {1'b0, p[PW-1:SW]} + (b[0] ? {1'b0, a} : '0);

    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = RUN;
            RUN:  if (cnt == LAST) state_d = NORM;
            NORM: state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q <= state_d;
        end
    end

    // busy/done are registered from the current state, so they trail the FSM by one edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            a       <= '0;
            b       <= '0;
            p       <= '0;
            cnt     <= '0;
            mant    <= '0;
            inc_exp <= 1'b0;
            sticky  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            busy <= (state_q == RUN) || (state_q == NORM);
            done <= (state_q == DONE);
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a   <= {1'b1, man1};
                        b   <= {1'b1, man2};
                        p   <= '0;
                        cnt <= '0;
                    end
                end
                RUN: begin
                    p   <= {sum, p[SW-1:1]};
                    b   <= b >> 1;
                    cnt <= cnt + 1'b1;
                end
                NORM: begin
                    if (p[PW-1]) begin
                        inc_exp <= 1'b1;
                        mant    <= p[PW-2 -: MW];
                        sticky  <= |p[SW-1:0];
                    end else begin
                        inc_exp <= 1'b0;
                        mant    <= p[PW-3 -: MW];
                        sticky  <= |p[SW-2:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mant_mult_seq.sv
// Self-checking bench for mant_mult_seq: directed corner cases plus random operands
// compared against an arithmetic model of the normalized significand product.
module tb_mant_mult_seq;

    localparam int MW = 23;

    logic          clk;
    logic          resetn;
    logic          start;
    logic [MW-1:0] man1, man2;
    logic [MW-1:0] mant;
    logic          inc_exp, sticky, busy, done;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [MW-1:0] mant;
        logic          inc;
        logic          sticky;
    } res_t;

    res_t last_exp;

    mant_mult_seq #(.MW(MW)) dut (
        .clk     (clk),
        .resetn  (resetn),
        .start   (start),
        .man1    (man1),
        .man2    (man2),
        .mant    (mant),
        .inc_exp (inc_exp),
        .sticky  (sticky),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Product of the two significands as real numbers scaled by 2^46; >= 2.0 means >= 2^47.
    function automatic res_t model(input logic [MW-1:0] m1, input logic [MW-1:0] m2);
        longint unsigned x, y, prod, scale;
        res_t r;
        x = 64'h80_0000 + 64'(m1);
        y = 64'h80_0000 + 64'(m2);
        prod = x * y;
        scale = (prod >= 64'h8000_0000_0000) ? 64'h100_0000 : 64'h80_0000;
        r.inc    = (scale == 64'h100_0000);
        r.mant   = MW'((prod / scale) % 64'h80_0000);
        r.sticky = (prod % scale) != 0;
        return r;
    endfunction

    task automatic do_op(input string tag, input logic [MW-1:0] m1, input logic [MW-1:0] m2);
        res_t e;
        int k, nbusy;
        bit seen;
        logic [MW-1:0] mant_before;
        e = model(m1, m2);
        @(negedge clk);
        man1 = m1; man2 = m2; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        man1 = MW'($urandom);
        man2 = MW'($urandom);
        k = 0; nbusy = 0; seen = 0; mant_before = '0;
        while (!seen && k < 40) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            if (done) seen = 1;
            else if (busy) nbusy++;
            if (k == 24) mant_before = mant;
        end
        check({tag, "_latency"}, 48'(k), 48'd26);
        check({tag, "_busy_cycles"}, 48'(nbusy), 48'd25);
        check({tag, "_busy_at_done"}, 48'(busy), 48'd0);
        check({tag, "_hold_prev"}, 48'(mant_before), 48'(last_exp.mant));
        check({tag, "_mant"}, 48'(mant), 48'(e.mant));
        check({tag, "_inc_exp"}, 48'(inc_exp), 48'(e.inc));
        check({tag, "_sticky"}, 48'(sticky), 48'(e.sticky));
        @(negedge clk);
        check({tag, "_done_pulse"}, 48'(done), 48'd0);
        last_exp = e;
    endtask

    initial begin
        int done_cnt, first_at, second_at, stray;
        res_t e;

        resetn = 1'b0; start = 1'b0; man1 = '0; man2 = '0;
        last_exp = '{mant: '0, inc: 1'b0, sticky: 1'b0};
        #12;
        check("rst_mant", 48'(mant), 48'd0);
        check("rst_flags", 48'({inc_exp, sticky, busy, done}), 48'd0);
        @(negedge clk);
        resetn = 1'b1;

        do_op("identity", 23'h000000, 23'h000000);
        do_op("overflow", 23'h400000, 23'h400000);
        check("overflow_const_mant", 48'(mant), 48'h100000);
        do_op("nonnorm", 23'h400000, 23'h000000);
        check("nonnorm_const_mant", 48'(mant), 48'h400000);
        do_op("max", 23'h7FFFFF, 23'h7FFFFF);
        check("max_const", 48'({inc_exp, sticky, mant}), {24'd0, 1'b1, 1'b1, 23'h7FFFFE});

        for (int i = 0; i < 8; i++) begin
            do_op($sformatf("rand%0d", i), MW'($urandom), MW'($urandom));
        end

        // start held high for 40 cycles: exactly two accepted operations, at +0 and +27.
        @(negedge clk);
        man1 = 23'h400000; man2 = 23'h400000; start = 1'b1;
        done_cnt = 0; first_at = -1; second_at = -1;
        for (int k = 0; k <= 60; k++) begin
            @(posedge clk);
            if (k == 39) #1 start = 1'b0;
            @(negedge clk);
            if (done) begin
                done_cnt++;
                if (first_at < 0) first_at = k;
                else if (second_at < 0) second_at = k;
            end
        end
        check("held_done_count", 48'(done_cnt), 48'd2);
        check("held_first_done", 48'(first_at), 48'd26);
        check("held_second_done", 48'(second_at), 48'd53);
        e = model(23'h400000, 23'h400000);
        check("held_mant", 48'(mant), 48'(e.mant));
        check("held_inc_exp", 48'(inc_exp), 48'(e.inc));
        last_exp = e;

        // Reset mid-operation: outputs clear asynchronously and no done follows.
        do_op("pre_reset", 23'h7FFFFF, 23'h7FFFFF);
        @(negedge clk);
        man1 = 23'h123456; man2 = 23'h654321; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        check("abort_mant", 48'(mant), 48'd0);
        check("abort_flags", 48'({inc_exp, sticky, busy, done}), 48'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        stray = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) stray++;
        end
        check("abort_no_done", 48'(stray), 48'd0);
        last_exp = '{mant: '0, inc: 1'b0, sticky: 1'b0};
        do_op("post_reset", 23'h400000, 23'h400000);
        check("post_reset_const", 48'({inc_exp, mant}), {24'd0, 1'b1, 23'h100000});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mant_mult_seq.md
Name: mant_mult_seq

Overview:
- Sequential shift-and-add multiplier for the 24-bit significands (hidden 1 restored) of two single-precision operands in the floating-point multiply datapath.
- Produces the normalized 23-bit fraction of the product and the `inc_exp` flag consumed by the exponent adder, which adds 1 to the biased exponent sum when `inc_exp` is set.
- Also produces a sticky bit for downstream rounding.
- Sits beside the exponent adder. Its registered outputs drive that adder's `inc_exp` input directly.

Parameters:
- MW, 23, stored fraction width; internal significand width is MW+1, product width is 2*(MW+1).

Ports:
- clk  input  1  system clock, rising edge.
- resetn  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- man1  input  MW  fraction of operand 1 (hidden 1 implied).
- man2  input  MW  fraction of operand 2 (hidden 1 implied).
- mant  output  MW  normalized product fraction, truncated.
- inc_exp  output  1  1 when the raw product is >= 2.0 (normalization right shift performed).
- sticky  output  1  OR of all product bits discarded below mant.
- busy  output  1  high in RUN and NORM.
- done  output  1  one-cycle pulse when mant/inc_exp/sticky are valid.

Behaviour:
- Reset, asynchronous on resetn low:
  - state=IDLE, counter=0.
  - Operand and accumulator registers cleared.
  - mant=0, inc_exp=0, sticky=0, busy=0, done=0.
- Reset asserted mid-operation aborts the operation. No done is produced for it.
- States: IDLE, RUN, NORM, DONE.
- IDLE:
  - On a rising edge with start=1:
    - A={1,man1}, B={1,man2}.
    - 48-bit product register P=0, cnt=0.
    - Go to RUN.
  - Otherwise stay. Outputs hold their last values.
- RUN: one iteration per clock, 24 iterations (cnt 0..23).
  - Each iteration adds A into the upper 25 bits of P if the current multiplier bit B[cnt] is 1, then shifts right one.
  - Any equivalent radix-2 scheme is acceptable, provided it takes exactly 24 RUN cycles.
  - After the 24th iteration, P equals A*B exactly, with no overflow beyond 48 bits.
  - Then go to NORM.
- NORM: a single cycle that registers the outputs.
  - If P[47]=1: inc_exp=1, mant=P[46:24], sticky=|P[23:0].
  - Else: inc_exp=0, mant=P[45:23], sticky=|P[22:0].
  - P[46] is guaranteed 1 when P[47]=0, since both operands are >= 1.0.
  - Then go to DONE.
- DONE: done=1 for exactly this cycle, busy=0, then go to IDLE.
- Latency: start sampled at edge N gives done high in the cycle following edge N+26. The next start is accepted at edge N+27 at the earliest.
- busy=1 from edge N+1 through edge N+25 (RUN and NORM).
- start while not in IDLE is ignored. It is not queued.
- mant/inc_exp/sticky change only at the NORM edge or at reset. They stay stable from NORM until the next operation's NORM.
- man1/man2 are captured at the start edge. Later changes to them do not affect the result.
- No special-value handling: zero, denormal, Inf and NaN are handled outside this block. Operands are always treated as normal numbers.

Test Plan:
- Identity: man1=0x000000, man2=0x000000, start pulse → done exactly 26 cycles after the start edge; mant=0x000000, inc_exp=0, sticky=0.
- Overflow into normalization: man1=man2=0x400000 (1.5×1.5=2.25) → inc_exp=1, mant=0x100000, sticky=0.
- Non-normalizing product: man1=0x400000, man2=0x000000 (1.5×1.0) → inc_exp=0, mant=0x400000, sticky=0.
- Maximum significands: man1=man2=0x7FFFFF → inc_exp=1, mant=0x7FFFFE, sticky=1.
- Start while busy: start=1 held for 40 cycles with man1=man2=0x400000 → first result is done at +26. A second operation begins only at edge +27. Exactly one done per accepted start, and no done appears mid-RUN.
- Reset mid-operation: resetn driven low 10 cycles after start → all outputs 0 immediately (asynchronously), no done pulse. After release, a new start with 0x400000×0x400000 completes normally with inc_exp=1, mant=0x100000.
